// File: rtl/neuraedge_pwr_pkg.sv
// +----------------------------------------------------------------------------+
// | neuraedge_pwr_pkg : CSR map, governor FSM states and STATUS field layout   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package neuraedge_pwr_pkg;

   localparam logic [7:0] C_OFF_CTRL       = 8'h00;
   localparam logic [7:0] C_OFF_WINDOW     = 8'h04;
   localparam logic [7:0] C_OFF_BUDGET     = 8'h08;
   localparam logic [7:0] C_OFF_HYST       = 8'h0C;
   localparam logic [7:0] C_OFF_STATUS     = 8'h10;
   localparam logic [7:0] C_OFF_LAST_DELTA = 8'h14;
   localparam logic [7:0] C_OFF_EVAL_COUNT = 8'h18;

   localparam int C_CTRL_EN_BIT      = 0;
   localparam int C_CTRL_IRQ_CLR_BIT = 1;

   // STATUS = {24'b0, irq, state[1:0], pad[1:0], level[2:0]}
   localparam int C_STATUS_LEVEL_LSB = 0;
   localparam int C_STATUS_STATE_LSB = 5;
   localparam int C_STATUS_IRQ_BIT   = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SNAP   = 2'd1,
      ST_WINDOW = 2'd2,
      ST_EVAL   = 2'd3
   } gov_state_e;

endpackage

`default_nettype wire

// File: rtl/tile_issue_duty_gate.sv
// +----------------------------------------------------------------------------+
// | tile_issue_duty_gate : free-running phase counter; blocks issue for the    |
// | first level_i phases of every 2**LEVEL_BITS cycles.  Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_issue_duty_gate #(
   parameter int LEVEL_BITS = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [LEVEL_BITS-1:0] level_i,
   output logic                  issue_enable_o
);

   localparam logic [LEVEL_BITS-1:0] C_PH_ONE = LEVEL_BITS'(1);

   logic [LEVEL_BITS-1:0] ph_q;
   logic [LEVEL_BITS-1:0] ph_d;
   logic                  issue_q;
   logic                  issue_d;

   always_comb begin
      ph_d    = ph_q + C_PH_ONE;
      issue_d = (ph_q >= level_i);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ph_q    <= '0;
         issue_q <= 1'b1;
      end else begin
         ph_q    <= ph_d;
         issue_q <= issue_d;
      end
   end

   assign issue_enable_o = issue_q;

endmodule

`default_nettype wire

// File: rtl/tile_energy_governor.sv
// +----------------------------------------------------------------------------+
// | tile_energy_governor : windowed energy-delta vs budget controller driving  |
// | a throttle level and issue duty gate.  Rev 1.0                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_energy_governor
   import neuraedge_pwr_pkg::*;
#(
   parameter int         LEVEL_BITS = 3,
   parameter int         MAX_LEVEL  = 6,
   parameter int         MIN_WINDOW = 16,
   parameter logic [7:0] CSR_BASE   = 8'h40
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [63:0]           energy_pj,
   input  logic                  csr_valid,
   input  logic                  csr_write,
   input  logic [7:0]            csr_addr,
   input  logic [31:0]           csr_wdata,
   output logic [31:0]           csr_rdata,
   output logic                  csr_ready,
   output logic                  issue_enable,
   output logic [LEVEL_BITS-1:0] throttle_level,
   output logic                  window_done,
   output logic                  over_budget_irq
);

   localparam logic [31:0]           C_MIN_WIN   = 32'(MIN_WINDOW);
   localparam logic [LEVEL_BITS-1:0] C_MAX_LEVEL = LEVEL_BITS'(MAX_LEVEL);
   localparam logic [LEVEL_BITS-1:0] C_LVL_ONE   = LEVEL_BITS'(1);

   gov_state_e            state_q, state_d;
   logic                  en_q, en_d;
   logic                  irq_q, irq_d;
   logic [31:0]           window_q, window_d;
   logic [31:0]           budget_q, budget_d;
   logic [31:0]           budget_act_q, budget_act_d;
   logic [31:0]           hyst_q, hyst_d;
   logic [31:0]           last_delta_q, last_delta_d;
   logic [31:0]           eval_cnt_q, eval_cnt_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [63:0]           e0_q, e0_d;
   logic [LEVEL_BITS-1:0] level_q, level_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  ready_q, ready_d;

   logic [7:0]  w_off;
   logic        w_wr;
   logic        w_rd;
   logic [31:0] w_win_eff;
   logic [63:0] w_delta;
   logic [31:0] w_dsat;
   logic        w_over;
   logic        w_under;
   logic        w_eval;
   logic [31:0] w_status;
   logic [31:0] w_rmux;

   assign w_off     = csr_addr - CSR_BASE;
   assign w_wr      = csr_valid & csr_write;
   assign w_rd      = csr_valid & ~csr_write;
   assign w_win_eff = (window_q < C_MIN_WIN) ? C_MIN_WIN : window_q;
   // Modular subtraction absorbs a wrap of the free-running energy counter.
   assign w_delta   = energy_pj - e0_q;
   assign w_dsat    = (|w_delta[63:32]) ? 32'hFFFF_FFFF : w_delta[31:0];
   assign w_over    = (w_dsat > budget_act_q);
   assign w_under   = (({1'b0, w_dsat} + {1'b0, hyst_q}) < {1'b0, budget_act_q});
   assign w_eval    = (state_q == ST_EVAL) && en_q;

   always_comb begin
      w_status = '0;
      w_status[C_STATUS_LEVEL_LSB +: LEVEL_BITS] = level_q;
      w_status[C_STATUS_STATE_LSB +: 2]          = state_q;
      w_status[C_STATUS_IRQ_BIT]                 = irq_q;
   end

   always_comb begin
      case (w_off)
         C_OFF_CTRL:       w_rmux = {31'b0, en_q};
         C_OFF_WINDOW:     w_rmux = window_q;
         C_OFF_BUDGET:     w_rmux = budget_q;
         C_OFF_HYST:       w_rmux = hyst_q;
         C_OFF_STATUS:     w_rmux = w_status;
         C_OFF_LAST_DELTA: w_rmux = last_delta_q;
         C_OFF_EVAL_COUNT: w_rmux = eval_cnt_q;
         default:          w_rmux = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      en_d         = en_q;
      irq_d        = irq_q;
      window_d     = window_q;
      budget_d     = budget_q;
      budget_act_d = budget_act_q;
      hyst_d       = hyst_q;
      last_delta_d = last_delta_q;
      eval_cnt_d   = eval_cnt_q;
      cnt_d        = cnt_q;
      e0_d         = e0_q;
      level_d      = level_q;
      ready_d      = csr_valid;
      rdata_d      = w_rd ? w_rmux : '0;

      if (w_wr) begin
         case (w_off)
            C_OFF_CTRL: begin
               en_d = csr_wdata[C_CTRL_EN_BIT];
               if (csr_wdata[C_CTRL_IRQ_CLR_BIT]) irq_d = 1'b0;
            end
            C_OFF_WINDOW: window_d = csr_wdata;
            C_OFF_BUDGET: budget_d = csr_wdata;
            C_OFF_HYST:   hyst_d   = csr_wdata;
            default: ;
         endcase
      end

      if (!en_q) begin
         state_d = ST_IDLE;
         level_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_SNAP;
            ST_SNAP: begin
               e0_d         = energy_pj;
               cnt_d        = w_win_eff - 32'd1;
               budget_act_d = budget_q;
               state_d      = ST_WINDOW;
            end
            // Leaving on cnt==1 places EVAL exactly W cycles after SNAP.
            ST_WINDOW: begin
               cnt_d = cnt_q - 32'd1;
               if (cnt_q <= 32'd1) state_d = ST_EVAL;
            end
            ST_EVAL: begin
               last_delta_d = w_dsat;
               eval_cnt_d   = eval_cnt_q + 32'd1;
               if (w_over) begin
                  level_d = (level_q >= C_MAX_LEVEL) ? C_MAX_LEVEL : level_q + C_LVL_ONE;
                  irq_d   = 1'b1;
               end else if (w_under) begin
                  level_d = (level_q == '0) ? '0 : level_q - C_LVL_ONE;
               end
               state_d = ST_SNAP;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         en_q         <= 1'b0;
         irq_q        <= 1'b0;
         window_q     <= '0;
         budget_q     <= '0;
         budget_act_q <= '0;
         hyst_q       <= '0;
         last_delta_q <= '0;
         eval_cnt_q   <= '0;
         cnt_q        <= '0;
         e0_q         <= '0;
         level_q      <= '0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         irq_q        <= irq_d;
         window_q     <= window_d;
         budget_q     <= budget_d;
         budget_act_q <= budget_act_d;
         hyst_q       <= hyst_d;
         last_delta_q <= last_delta_d;
         eval_cnt_q   <= eval_cnt_d;
         cnt_q        <= cnt_d;
         e0_q         <= e0_d;
         level_q      <= level_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
      end
   end

   tile_issue_duty_gate #(
      .LEVEL_BITS (LEVEL_BITS)
   ) u_duty_gate (
      .clk            (clk),
      .reset_n        (reset_n),
      .level_i        (level_q),
      .issue_enable_o (issue_enable)
   );

   assign csr_rdata       = rdata_q;
   assign csr_ready       = ready_q;
   assign throttle_level  = level_q;
   assign window_done     = w_eval;
   assign over_budget_irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_energy_governor.sv
// +----------------------------------------------------------------------------+
// | tb_tile_energy_governor : directed vectors for tile_energy_governor        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tile_energy_governor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] energy_pj;
   logic        csr_valid;
   logic        csr_write;
   logic [7:0]  csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_ready;
   logic        issue_enable;
   logic [2:0]  throttle_level;
   logic        window_done;
   logic        over_budget_irq;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] rate;
   logic [31:0] rd;

   tile_energy_governor dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .energy_pj       (energy_pj),
      .csr_valid       (csr_valid),
      .csr_write       (csr_write),
      .csr_addr        (csr_addr),
      .csr_wdata       (csr_wdata),
      .csr_rdata       (csr_rdata),
      .csr_ready       (csr_ready),
      .issue_enable    (issue_enable),
      .throttle_level  (throttle_level),
      .window_done     (window_done),
      .over_budget_irq (over_budget_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every bench cycle ends on a falling edge; the energy ramp advances here.
   task automatic tick();
      @(negedge clk);
      energy_pj = energy_pj + rate;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      csr_valid = 1'b1; csr_write = 1'b1; csr_addr = a; csr_wdata = d;
      tick();
      check("wr_ready", csr_ready, 1);
      csr_valid = 1'b0; csr_write = 1'b0;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
      csr_valid = 1'b1; csr_write = 1'b0; csr_addr = a;
      tick();
      check("rd_ready", csr_ready, 1);
      d = csr_rdata;
      csr_valid = 1'b0;
   endtask

   // Returns on the falling edge of the SNAP cycle that follows an EVAL.
   task automatic sync_eval();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!window_done && n < 400);
      check("done_seen", window_done, 1);
      tick();
   endtask

   task automatic apply_window(input logic [63:0] delta);
      tick();
      energy_pj = energy_pj + delta;
      sync_eval();
   endtask

   initial begin
      int n_lo;
      int n_done;
      int n;
      reset_n = 1'b0; energy_pj = '0; rate = '0;
      csr_valid = 1'b0; csr_write = 1'b0; csr_addr = '0; csr_wdata = '0;

      // Reset state
      repeat (3) tick();
      check("rst_issue", issue_enable, 1);
      check("rst_level", throttle_level, 0);
      check("rst_irq", over_budget_irq, 0);
      check("rst_ready", csr_ready, 0);
      check("rst_done", window_done, 0);
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         bus_rd(8'h40 + 8'(i * 4), rd);
         check("rst_csr", rd, 0);
      end

      // Over budget: 20 pJ/cycle over 100 cycles = 2000 pJ
      bus_wr(8'h44, 32'd100);
      bus_wr(8'h48, 32'd1000);
      bus_wr(8'h4C, 32'd100);
      rate = 64'd20;
      bus_wr(8'h40, 32'd1);
      for (int i = 1; i <= 7; i++) begin
         sync_eval();
         check("ramp_level", throttle_level, (i > 6) ? 6 : i);
         if (i == 1) check("ramp_irq", over_budget_irq, 1);
      end
      rate = '0;
      bus_rd(8'h50, rd);
      check("status_sat", rd, 32'h0000_00A6);
      bus_rd(8'h54, rd);
      check("delta_2000", rd, 32'd2000);

      // Zero-delta windows walk the level down
      for (int i = 5; i >= 3; i--) begin
         apply_window(64'd0);
         check("down_level", throttle_level, i);
      end

      // Hysteresis band
      apply_window(64'd950);
      check("hyst_hold", throttle_level, 3);
      apply_window(64'd899);
      check("hyst_drop", throttle_level, 2);
      bus_wr(8'h40, 32'd3);
      check("irq_w1c", over_budget_irq, 0);

      // Duty gate at level 2 during an exactly-at-budget window
      tick();
      n_lo = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (!issue_enable) n_lo++;
      end
      energy_pj = energy_pj + 64'd1000;
      sync_eval();
      check("duty_lows", n_lo, 16);
      check("eq_budget_hold", throttle_level, 2);
      check("eq_budget_noirq", over_budget_irq, 0);

      // Energy counter wrap, then saturation
      energy_pj = 64'hFFFF_FFFF_FFFF_FF00;
      apply_window(64'h200);
      check("wrap_level", throttle_level, 1);
      bus_rd(8'h54, rd);
      check("wrap_delta", rd, 32'h200);
      apply_window(64'h2_0000_0000);
      check("sat_level", throttle_level, 2);
      check("sat_irq", over_budget_irq, 1);
      bus_rd(8'h54, rd);
      check("sat_delta", rd, 32'hFFFF_FFFF);

      // irq set by EVAL wins over a W1C in the same cycle
      sync_eval();
      check("pre_col_level", throttle_level, 1);
      bus_wr(8'h40, 32'd3);
      check("col_clear", over_budget_irq, 0);
      energy_pj = energy_pj + 64'd2000;
      repeat (99) tick();
      check("col_eval", window_done, 1);
      bus_wr(8'h40, 32'd3);
      check("col_irq", over_budget_irq, 1);
      check("col_level", throttle_level, 2);

      // WINDOW below the floor runs 16 cycles
      bus_wr(8'h44, 32'd5);
      sync_eval();
      check("win5_level", throttle_level, 1);
      n = 0;
      do begin
         tick();
         n++;
      end while (!window_done && n < 100);
      check("win_floor", n, 16);
      tick();
      check("floor_level", throttle_level, 0);

      // BUDGET=0: any nonzero delta raises the level, zero delta holds
      bus_wr(8'h48, 32'd0);
      sync_eval();
      check("b0_pending", throttle_level, 0);
      apply_window(64'd1);
      check("b0_up", throttle_level, 1);
      apply_window(64'd0);
      check("b0_hold", throttle_level, 1);
      bus_rd(8'h7C, rd);
      check("unmapped", rd, 0);

      // Disable mid-window
      tick();
      bus_wr(8'h40, 32'd0);
      n_done = 0;
      n_lo   = 0;
      repeat (3) begin
         tick();
         if (window_done) n_done++;
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (window_done) n_done++;
         if (!issue_enable) n_lo++;
      end
      check("dis_done", n_done, 0);
      check("dis_issue_lows", n_lo, 0);
      check("dis_level", throttle_level, 0);
      bus_rd(8'h50, rd);
      check("dis_status", rd, 32'h0000_0080);
      bus_rd(8'h54, rd);
      check("dis_delta", rd, 0);
      bus_rd(8'h58, rd);
      check("eval_count", rd, 32'd22);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
